rob_multiport: RTL
==================

Name: rob_multiport

Overview:
- Parametrised successor to the single-writeback reorder buffer: in-order allocation, out-of-order completion over WB_PORTS writeback channels, in-order commit.
- Adds explicit valid/ready allocation, count-based full/empty, per-port registered result broadcast, commit back-pressure, and mispredict flush on commit.
- Sits between the decode/dispatch stage (allocation), the execution units (writeback) and the register file (commit).

Parameters:
- DEPTH, 8, number of entries; power of two, at least 2.
- TAG_W, $clog2(DEPTH), tag width.
- DATA_W, 32, result/PC width.
- WB_PORTS, 3, number of writeback channels (ALU, branch, LSQ).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- alloc_valid  in  1  dispatch requests an entry
- alloc_ready  out  1  entry can be accepted this cycle
- alloc_pc  in  DATA_W  instruction PC
- alloc_has_rd  in  1  instruction writes a register
- alloc_rd  in  5  destination register
- alloc_tag  out  TAG_W  tag given to the instruction when allocation fires
- wb_valid  in  WB_PORTS  per-port completion
- wb_tag  in  WB_PORTS*TAG_W  packed, port i at [i*TAG_W +: TAG_W]
- wb_data  in  WB_PORTS*DATA_W  packed result
- wb_mispredict  in  WB_PORTS  completion is a mispredicted control transfer
- wb_target  in  WB_PORTS*DATA_W  correct redirect PC
- bcast_valid  out  WB_PORTS  registered result broadcast
- bcast_tag  out  WB_PORTS*TAG_W  broadcast tag
- bcast_data  out  WB_PORTS*DATA_W  broadcast data
- commit_stall  in  1  register file cannot accept a commit
- commit_valid  out  1  head entry retires this cycle
- commit_tag  out  TAG_W  head tag
- commit_has_rd  out  1  head entry writes a register
- commit_rd  out  5  head destination register
- commit_data  out  DATA_W  head result
- flush  out  1  one-cycle pipeline flush pulse
- flush_pc  out  DATA_W  redirect PC, valid while flush is 1
- count  out  TAG_W+1  occupied entries

Behaviour:
- Storage: per entry valid, done, mispredict, has_rd, rd, pc, data, target. Pointers head and tail are TAG_W bits and wrap modulo DEPTH. count tracks occupancy; empty when count==0, full when count==DEPTH.
- Reset (rst low, asynchronous): head, tail, count = 0; all entry valid/done = 0; bcast_valid = 0; flush = 0; flush_pc = 0. Combinational outputs are then: commit_valid = 0, alloc_ready = 1, alloc_tag = 0.
- alloc_tag = tail. Allocation fires when alloc_valid && alloc_ready. On fire, the entry at tail is written with valid=1, done=0, mispredict=0, and tail advances by 1.
- Writeback: for each port i with wb_valid[i] and entry[wb_tag].valid && !done, the entry captures data, target and mispredict, and sets done=1 at the next edge. Writebacks to invalid or already-done entries are ignored. If several ports hit the same tag in one cycle, the highest port index wins.
- Broadcast: bcast_*[i] is a registered copy of writeback port i, one cycle of latency, only for accepted writebacks; otherwise bcast_valid[i] = 0.
- Commit (combinational from registered state): commit_valid = entry[head].valid && done && !commit_stall && !flush. On commit, the head entry is cleared and head advances. Commit rate is at most one per cycle.
- alloc_ready = (!full || commit_valid) && !flush && !(commit_valid && entry[head].mispredict).
- Simultaneous allocate and commit: count is unchanged. This is legal when full, and the freed slot is reused.
- Mispredict: when the committing head has mispredict=1, at the next edge flush=1, flush_pc = head target, all entries are invalidated, head = tail = 0 and count = 0. The mispredicting instruction itself commits normally. During the flush cycle, commits, allocations and writebacks are all blocked or ignored. flush deasserts after one cycle.
- A writeback in the same cycle as a commit of another tag is handled independently. A writeback for the tag being allocated in the same cycle is ignored.
- Reset asserted mid-operation clears all state immediately, with no commit or flush.

Test Plan:
- Reset, then allocate 8 instructions PC 0x100..0x11C with no writebacks -> alloc_tag 0..7, count=8, alloc_ready=0, commit_valid=0.
- Complete the full buffer out of order: port0 tag 3 data 0xAA, then port2 tag 0 data 0x11 -> bcast on tag 3 one cycle later; commit only after tag 0 completes; tags 0..3 retire in order once all are done.
- Full buffer with head done and alloc_valid held -> commit and allocate in the same cycle, new tag = old head tag, count stays 8.
- Ports 0 and 1 write tag 2 in the same cycle with 0x5 and 0x9 -> committed data 0x9, bcast_valid=2'b11 on ports 0 and 1.
- Tag 1 completes with mispredict and target 0x400 while 5 entries are live -> tag 1 commits, next cycle flush=1, flush_pc=0x400, count=0, next alloc_tag=0.
- commit_stall held high with head done -> commit_valid=0 and head unchanged. Assert rst mid-run -> count=0 and bcast_valid=0 immediately.

Source files
------------

// File: rtl/rob_multiport.sv
// Reorder buffer: in-order allocation, out-of-order completion over WB_PORTS writeback channels, in-order commit.
// Latency: writeback reaches entry state and the broadcast registers one cycle later; commit is combinational from registered state.
// Backpressure: alloc_ready drops when full without a freeing commit, during flush, and on a mispredicting commit; commit_stall holds the head.
module rob_multiport #(
    parameter int DEPTH    = 8,
    parameter int TAG_W    = $clog2(DEPTH),
    parameter int DATA_W   = 32,
    parameter int WB_PORTS = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         alloc_valid,
    output logic                         alloc_ready,
    input  logic [DATA_W-1:0]            alloc_pc,
    input  logic                         alloc_has_rd,
    input  logic [4:0]                   alloc_rd,
    output logic [TAG_W-1:0]             alloc_tag,
    input  logic [WB_PORTS-1:0]          wb_valid,
    input  logic [WB_PORTS*TAG_W-1:0]    wb_tag,
    input  logic [WB_PORTS*DATA_W-1:0]   wb_data,
    input  logic [WB_PORTS-1:0]          wb_mispredict,
    input  logic [WB_PORTS*DATA_W-1:0]   wb_target,
    output logic [WB_PORTS-1:0]          bcast_valid,
    output logic [WB_PORTS*TAG_W-1:0]    bcast_tag,
    output logic [WB_PORTS*DATA_W-1:0]   bcast_data,
    input  logic                         commit_stall,
    output logic                         commit_valid,
    output logic [TAG_W-1:0]             commit_tag,
    output logic                         commit_has_rd,
    output logic [4:0]                   commit_rd,
    output logic [DATA_W-1:0]            commit_data,
    output logic                         flush,
    output logic [DATA_W-1:0]            flush_pc,
    output logic [TAG_W:0]               count
);

    localparam logic [TAG_W:0]   FULL_CNT = (TAG_W+1)'(DEPTH);
    localparam logic [TAG_W-1:0] TAG_ONE  = TAG_W'(1);

    // Per-entry state
    logic [DEPTH-1:0]  ent_valid;
    logic [DEPTH-1:0]  ent_done;
    logic [DEPTH-1:0]  ent_mispredict;
    logic [DEPTH-1:0]  ent_has_rd;
    logic [4:0]        ent_rd     [DEPTH];
    logic [DATA_W-1:0] ent_pc     [DEPTH];
    logic [DATA_W-1:0] ent_data   [DEPTH];
    logic [DATA_W-1:0] ent_target [DEPTH];

    logic [TAG_W-1:0]  head;
    logic [TAG_W-1:0]  tail;
    logic [TAG_W:0]    cnt;

    // Unpacked writeback channels
    logic [TAG_W-1:0]    wb_tag_a    [WB_PORTS];
    logic [DATA_W-1:0]   wb_data_a   [WB_PORTS];
    logic [DATA_W-1:0]   wb_target_a [WB_PORTS];
    logic [WB_PORTS-1:0] wb_accept;

    logic full;
    logic alloc_fire;
    logic mp_commit;

    // Unpack each writeback port and accept it only for a live, not yet completed entry outside a flush
    always_comb begin
        for (int i = 0; i < WB_PORTS; i++) begin
            wb_tag_a[i]    = wb_tag[i*TAG_W +: TAG_W];
            wb_data_a[i]   = wb_data[i*DATA_W +: DATA_W];
            wb_target_a[i] = wb_target[i*DATA_W +: DATA_W];
            wb_accept[i]   = wb_valid[i] && ent_valid[wb_tag_a[i]]
                             && !ent_done[wb_tag_a[i]] && !flush;
        end
    end

    assign full          = (cnt == FULL_CNT);
    assign commit_valid  = ent_valid[head] && ent_done[head] && !commit_stall && !flush;
    assign mp_commit     = commit_valid && ent_mispredict[head];
    // A commit in the same cycle frees the head slot, so a full buffer can still accept
    assign alloc_ready   = (!full || commit_valid) && !flush && !mp_commit;
    assign alloc_fire    = alloc_valid && alloc_ready;

    assign alloc_tag     = tail;
    assign commit_tag    = head;
    assign commit_has_rd = ent_has_rd[head];
    assign commit_rd     = ent_rd[head];
    assign commit_data   = ent_data[head];
    assign count         = cnt;

    // Head/tail pointers and occupancy; a mispredicting commit rewinds the whole buffer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else if (mp_commit) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            if (commit_valid) begin
                head <= head + TAG_ONE;
            end
            if (alloc_fire) begin
                tail <= tail + TAG_ONE;
            end
            cnt <= cnt + (TAG_W+1)'(alloc_fire) - (TAG_W+1)'(commit_valid);
        end
    end

    // Entry state: flush wipes all entries; otherwise writebacks (highest port last), commit clear, then allocation
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ent_valid      <= '0;
            ent_done       <= '0;
            ent_mispredict <= '0;
            ent_has_rd     <= '0;
            for (int e = 0; e < DEPTH; e++) begin
                ent_rd[e]     <= '0;
                ent_pc[e]     <= '0;
                ent_data[e]   <= '0;
                ent_target[e] <= '0;
            end
        end else if (mp_commit) begin
            ent_valid      <= '0;
            ent_done       <= '0;
            ent_mispredict <= '0;
        end else begin
            for (int i = 0; i < WB_PORTS; i++) begin
                if (wb_accept[i]) begin
                    ent_done[wb_tag_a[i]]       <= 1'b1;
                    ent_mispredict[wb_tag_a[i]] <= wb_mispredict[i];
                    ent_data[wb_tag_a[i]]       <= wb_data_a[i];
                    ent_target[wb_tag_a[i]]     <= wb_target_a[i];
                end
            end
            if (commit_valid) begin
                ent_valid[head]      <= 1'b0;
                ent_done[head]       <= 1'b0;
                ent_mispredict[head] <= 1'b0;
            end
            // Allocation comes last so a slot freed by this cycle's commit is reused cleanly
            if (alloc_fire) begin
                ent_valid[tail]      <= 1'b1;
                ent_done[tail]       <= 1'b0;
                ent_mispredict[tail] <= 1'b0;
                ent_has_rd[tail]     <= alloc_has_rd;
                ent_rd[tail]         <= alloc_rd;
                ent_pc[tail]         <= alloc_pc;
            end
        end
    end

    // Registered broadcast of every accepted writeback, one per port
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bcast_valid <= '0;
            bcast_tag   <= '0;
            bcast_data  <= '0;
        end else begin
            bcast_valid <= wb_accept;
            for (int i = 0; i < WB_PORTS; i++) begin
                if (wb_accept[i]) begin
                    bcast_tag[i*TAG_W +: TAG_W]    <= wb_tag_a[i];
                    bcast_data[i*DATA_W +: DATA_W] <= wb_data_a[i];
                end
            end
        end
    end

    // One-cycle flush pulse carrying the redirect target of the mispredicting commit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flush    <= 1'b0;
            flush_pc <= '0;
        end else begin
            flush <= mp_commit;
            if (mp_commit) begin
                flush_pc <= ent_target[head];
            end
        end
    end

endmodule
